// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// SPI bus initiator, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
// It drives mosi before each rising sck edge and samples miso on the rising
// edge. It is intended to pair with a slave that shifts miso on the falling
// edge after synchronising sck.
//
// Frame timing with H = 2**CLK_DIV clk cycles per sck half-period:
//   accept edge 0 -> SETUP (H) -> TRANSFER (8 x 2H) -> TAIL (H) -> new_data
//   The new_data pulse follows edge 18H. busy drops in the same cycle.
//
// Parameters:
//   CLK_DIV   log2 of the sck half-period in clk cycles. Legal range is 3..8.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   start      transfer request, sampled only while idle
//   data_in    byte to transmit, latched when start is accepted
//   data_out   last received byte, held until the next completion
//   new_data   one-cycle pulse at transfer completion
//   busy       high from the cycle after acceptance until completion
//   miso       serial data from the slave (sampled directly, no synchroniser)
//   mosi       serial data to the slave
//   sck        serial clock
//   ss         slave select, active-low
//   ss_hold    (only with SPI_MASTER_SS_HOLD_EN) keep ss asserted after a frame
//
// Optional feature macro: SPI_MASTER_SS_HOLD_EN
//   When defined, an ss_hold input is added. It is sampled at the end of TAIL.
//   If ss_hold is 1 there, ss stays low in IDLE. ss is released at the first
//   idle edge with ss_hold=0 and start=0.
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int CLK_DIV = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       new_data,
    output logic       busy,
    input  logic       miso,
    output logic       mosi,
    output logic       sck,
    output logic       ss
`ifdef SPI_MASTER_SS_HOLD_EN
    ,
    input  logic       ss_hold
`endif
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETUP    = 2'd1;
    localparam logic [1:0] ST_TRANSFER = 2'd2;
    localparam logic [1:0] ST_TAIL     = 2'd3;

    // The phase counter must reach 2H-1, which needs CLK_DIV+1 bits.
    localparam int          CTR_W     = CLK_DIV + 1;
    localparam int unsigned H         = 32'd1 << CLK_DIV;
    localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(32'd1);
    localparam logic [CTR_W-1:0] CTR_H_M1 = CTR_W'(H - 32'd1);
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'((32'd2 * H) - 32'd1);

    // State registers
    logic [1:0]       state_r;
    logic [CTR_W-1:0] ctr_r;
    logic [2:0]       bit_ct_r;
    logic [7:0]       shift_r;
    logic             sck_r;
    logic             ss_r;
    logic             mosi_r;
    logic             busy_r;
    logic             new_data_r;
    logic [7:0]       data_out_r;

    // Next-state values
    logic [1:0]       state_s;
    logic [CTR_W-1:0] ctr_s;
    logic [2:0]       bit_ct_s;
    logic [7:0]       shift_s;
    logic             sck_s;
    logic             ss_s;
    logic             mosi_s;
    logic             busy_s;
    logic             new_data_s;
    logic [7:0]       data_out_s;
    logic             ss_hold_s;

`ifdef SPI_MASTER_SS_HOLD_EN
    assign ss_hold_s = ss_hold;
`else
    // Without the hold feature, ss is always released after TAIL.
    assign ss_hold_s = 1'b0;
`endif

    // Next-state and output computation for the frame sequencer
    always_comb begin
        state_s    = state_r;
        ctr_s      = ctr_r;
        bit_ct_s   = bit_ct_r;
        shift_s    = shift_r;
        sck_s      = sck_r;
        ss_s       = ss_r;
        mosi_s     = mosi_r;
        busy_s     = busy_r;
        new_data_s = 1'b0;
        data_out_s = data_out_r;

        case (state_r)
            ST_IDLE: begin
                sck_s  = 1'b0;
                busy_s = 1'b0;
                if (start) begin
                    // Present the MSB immediately so it is stable long before
                    // the first rising edge.
                    state_s  = ST_SETUP;
                    shift_s  = data_in;
                    ss_s     = 1'b0;
                    mosi_s   = data_in[7];
                    busy_s   = 1'b1;
                    ctr_s    = CTR_ZERO;
                    bit_ct_s = 3'd0;
                end else if (!ss_hold_s) begin
                    ss_s = 1'b1;
                end else begin
                    ss_s = ss_r;
                end
            end

            ST_SETUP: begin
                // ss-to-first-edge setup time of H cycles with sck low
                if (ctr_r == CTR_H_M1) begin
                    state_s = ST_TRANSFER;
                    ctr_s   = CTR_ZERO;
                end else begin
                    ctr_s = ctr_r + CTR_ONE;
                end
            end

            ST_TRANSFER: begin
                if (ctr_r == CTR_H_M1) begin
                    // Rising edge: capture miso into the vacated LSB
                    ctr_s   = ctr_r + CTR_ONE;
                    sck_s   = 1'b1;
                    shift_s = {shift_r[6:0], miso};
                end else if (ctr_r == CTR_LAST) begin
                    // Falling edge: advance to the next bit or finish
                    ctr_s    = CTR_ZERO;
                    sck_s    = 1'b0;
                    bit_ct_s = bit_ct_r + 3'd1;
                    if (bit_ct_r == 3'd7) begin
                        state_s = ST_TAIL;
                    end else begin
                        // After the shift, bit 7 holds the next bit to send.
                        mosi_s = shift_r[7];
                    end
                end else begin
                    ctr_s = ctr_r + CTR_ONE;
                end
            end

            ST_TAIL: begin
                // Hold ss low for H cycles after the last falling edge
                if (ctr_r == CTR_H_M1) begin
                    state_s    = ST_IDLE;
                    ctr_s      = CTR_ZERO;
                    ss_s       = ss_hold_s ? 1'b0 : 1'b1;
                    busy_s     = 1'b0;
                    mosi_s     = 1'b1;
                    data_out_s = shift_r;
                    new_data_s = 1'b1;
                end else begin
                    ctr_s = ctr_r + CTR_ONE;
                end
            end

            default: begin
                state_s  = ST_IDLE;
                ctr_s    = CTR_ZERO;
                bit_ct_s = 3'd0;
                sck_s    = 1'b0;
                ss_s     = 1'b1;
                mosi_s   = 1'b1;
                busy_s   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ctr_r      <= CTR_ZERO;
            bit_ct_r   <= 3'd0;
            shift_r    <= 8'h00;
            sck_r      <= 1'b0;
            ss_r       <= 1'b1;
            mosi_r     <= 1'b1;
            busy_r     <= 1'b0;
            new_data_r <= 1'b0;
            data_out_r <= 8'h00;
        end else begin
            state_r    <= state_s;
            ctr_r      <= ctr_s;
            bit_ct_r   <= bit_ct_s;
            shift_r    <= shift_s;
            sck_r      <= sck_s;
            ss_r       <= ss_s;
            mosi_r     <= mosi_s;
            busy_r     <= busy_s;
            new_data_r <= new_data_s;
            data_out_r <= data_out_s;
        end
    end

    assign data_out = data_out_r;
    assign new_data = new_data_r;
    assign busy     = busy_r;
    assign mosi     = mosi_r;
    assign sck      = sck_r;
    assign ss       = ss_r;

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI bus initiator, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- It generates sck and ss, shifts out mosi, and samples miso.
- It is the counterpart of the team's SPI slave receiver: it drives mosi before each rising sck edge and samples miso on the rising edge. The slave shifts miso out on the falling edge.
- It sits between on-chip logic (start/data handshake) and the off-chip SPI pins.

Parameters:
- CLK_DIV, 3, log2 of the sck half-period in clk cycles. H = 2^CLK_DIV, sck period = 2H. Legal range 3..8; 3 is the minimum for a synchronising slave.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request a transfer; sampled only when busy=0
- data_in  input  8  byte to transmit; latched in the cycle start is accepted
- data_out  output  8  last received byte; valid when new_data=1 and held until the next completion
- new_data  output  1  one-cycle pulse at transfer completion
- busy  output  1  high from the cycle after acceptance until completion
- miso  input  1  serial data from the slave
- mosi  output  1  serial data to the slave
- sck  output  1  serial clock
- ss  output  1  slave select, active-low

Behaviour:
- Reset values: sck=0, ss=1, mosi=1, busy=0, new_data=0, data_out=8'h00. The state machine goes to IDLE and all counters clear.
- Reset mid-transfer aborts the frame: the reset values appear at the first clk edge with rst high, and no new_data pulse is generated.
- All outputs are registered.
- miso is sampled directly with no synchroniser. The slave must settle miso within H-1 cycles of the falling sck edge.
- States: IDLE, SETUP, TRANSFER, TAIL.
- IDLE:
  - Outputs: sck=0, ss=1, busy=0.
  - Transition: if start=1, latch data_in into shift_reg and go to SETUP. In that same edge: ss<=0, mosi<=data_in[7], busy<=1, ctr<=0, bit_ct<=0.
  - start while busy=1 is ignored; there is no queueing.
- SETUP: sck=0 for H cycles (ss-to-first-edge setup), then go to TRANSFER with ctr=0.
- TRANSFER:
  - ctr counts 0..2H-1 and wraps; sck is low for ctr < H and high for ctr >= H.
  - Rising edge (ctr H-1 -> H): shift_reg <= {shift_reg[6:0], miso}.
  - Falling edge (ctr wraps to 0): bit_ct++ (3-bit). If bit_ct was 7, go to TAIL with sck=0. Otherwise mosi <= shift_reg[7] (the next MSB).
  - Exactly 8 rising and 8 falling sck edges per frame.
- TAIL:
  - sck=0, ss=0 held for H cycles.
  - Then go to IDLE. In that edge: ss<=1, busy<=0, mosi<=1, data_out<=shift_reg, new_data<=1 for one cycle.
- Latency: start sampled at clk edge 0 -> new_data high after edge 18H (default 144 cycles) -> busy low in the same cycle.
- Back-to-back: start high during the new_data cycle is accepted (busy=0 then). ss has a one-cycle high gap before the next SETUP.
- data_in changes after acceptance have no effect on the frame in flight.

Optional Feature:
- Macro: SPI_MASTER_SS_HOLD_EN.
- Defined:
  - Adds input port ss_hold (1 bit), sampled at the TAIL->IDLE edge.
  - If ss_hold=1, ss stays 0 in IDLE.
  - ss returns to 1 at the first IDLE edge where ss_hold=0 and start=0.
  - A start accepted while ss is held goes through SETUP as normal, with no ss glitch.
- Not defined: no ss_hold port, and ss always deasserts at the end of TAIL.

Test Plan:
- Reset: hold rst 3 cycles, including once mid-frame at bit 4 -> sck=0, ss=1, mosi=1, busy=0, new_data=0, data_out=8'h00; no new_data pulse afterwards.
- Loopback with mosi tied to miso, CLK_DIV=3, data_in=8'hA5 -> new_data at 144 cycles after start, data_out=8'hA5, 8 sck periods of 16 cycles each.
- Slave model (sync flops, shifts on falling edge) preloaded with 8'h3C, master sends 8'h96 -> master data_out=8'h3C, slave receives 8'h96; mosi stable across every rising sck edge.
- Start pulsed again 20 cycles into a frame with data_in=8'hFF -> ignored; only one new_data pulse, and the frame carries the original byte.
- start held high continuously with data_in 8'h01 then 8'h02 -> two consecutive frames, ss high for exactly 1 cycle between them, received bytes in order.
- With SPI_MASTER_SS_HOLD_EN: ss_hold=1 on the first frame then 0 on the second -> ss low continuously across both frames, high after the second TAIL.
